dtmf_detect: RTL and testbench



---
 rtl/dtmf_pkg.sv | 66 ++++++
 rtl/dtmf_tone_period.sv | 82 ++++++++
 rtl/dtmf_detect.sv | 155 +++++++++++++++
 tb/tb_dtmf_detect.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dtmf_pkg.sv
// dtmf_pkg: shared definitions for the DTMF receive path.
//   - period band limits (in measurement ticks, inclusive) for the four row
//     and four column tones
//   - FSM state type for the key qualifier
//   - band classifier and {row,col} -> key code map (inverse of the tone
//     generator's map)
package dtmf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_QUALIFY,
        ST_PRESSED
    } dtmf_state_e;

    typedef enum logic {
        BAND_ROW,
        BAND_COL
    } band_sel_e;

    localparam int PERIOD_W = 11;
    localparam logic [PERIOD_W-1:0] PERIOD_MAX = 11'd2047;

    // Index = class: rows 697/770/852/941 Hz, cols 1209/1336/1477/1633 Hz.
    localparam logic [11:0] ROW_LO [4] = '{12'd1400, 12'd1267, 12'd1145, 12'd1037};
    localparam logic [11:0] ROW_HI [4] = '{12'd1470, 12'd1332, 12'd1204, 12'd1090};
    localparam logic [11:0] COL_LO [4] = '{12'd806,  12'd730,  12'd660,  12'd597};
    localparam logic [11:0] COL_HI [4] = '{12'd848,  12'd768,  12'd694,  12'd627};

    // Returns {valid, class}.
    function automatic logic [2:0] classify(input band_sel_e sel, input logic [11:0] ticks);
        logic [2:0] res;
        res = 3'b000;
        for (int i = 0; i < 4; i++) begin
            if (sel == BAND_ROW) begin
                if (ticks >= ROW_LO[i] && ticks <= ROW_HI[i]) res = {1'b1, 2'(i)};
            end else begin
                if (ticks >= COL_LO[i] && ticks <= COL_HI[i]) res = {1'b1, 2'(i)};
            end
        end
        return res;
    endfunction

    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = 4'hE;
            4'hD: code = 4'h0;
            4'hE: code = 4'hF;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/dtmf_tone_period.sv
// dtmf_tone_period: one tone channel. Synchronizes the comparator output,
// detects rising edges, counts prescaler ticks between edges and classifies
// each period into one of four bands.
// Ports:
//   clk, rst_n  system clock, async active-low reset
//   tick        shared prescaler tick (one period count per tick)
//   tone        raw 1-bit tone, asynchronous to clk
//   meas        1-cycle strobe: a period was measured or the counter timed out
//   vld, cls    during meas: the new result; otherwise the held last result
module dtmf_tone_period
    import dtmf_pkg::*;
#(
    parameter band_sel_e BAND = BAND_ROW
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       tone,
    output logic       meas,
    output logic       vld,
    output logic [1:0] cls
);

    logic                sync1, sync2, sync3;
    logic                edge_q;
    logic                edge_seen;
    logic [PERIOD_W-1:0] count;
    logic [11:0]         ticks;
    logic [2:0]          cls_res;
    logic                timeout;
    logic                meas_vld;
    logic                held_vld;
    logic [1:0]          held_cls;

    // A tick landing in the edge cycle belongs to the period that just ended.
    assign ticks    = {1'b0, count} + {11'b0, tick};
    assign cls_res  = classify(BAND, ticks);
    assign timeout  = tick && !edge_q && (count == PERIOD_MAX - 11'd1);
    assign meas     = (edge_q && edge_seen) || timeout;
    assign meas_vld = edge_q && cls_res[2];

    // Bypass so the consumer sees the fresh class in the strobe cycle.
    assign vld = meas ? meas_vld : held_vld;
    assign cls = meas ? cls_res[1:0] : held_cls;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            sync3     <= 1'b0;
            edge_q    <= 1'b0;
            edge_seen <= 1'b0;
            count     <= '0;
            held_vld  <= 1'b0;
            held_cls  <= 2'd0;
        end else begin
            sync1  <= tone;
            sync2  <= sync1;
            sync3  <= sync2;
            edge_q <= sync2 & ~sync3;

            if (edge_q)
                edge_seen <= 1'b1;
            else if (timeout)
                edge_seen <= 1'b0;

            // The count tops out at 2047 (timeout strobe on arrival), then
            // restarts so a silent channel keeps producing invalid strobes
            // every 2048 ticks; that is what lets a held key release.
            if (edge_q)
                count <= '0;
            else if (tick)
                count <= (count == PERIOD_MAX) ? '0 : count + 11'd1;

            if (meas) begin
                held_vld <= meas_vld;
                held_cls <= cls_res[1:0];
            end
        end
    end

endmodule

// File: rtl/dtmf_detect.sv
// dtmf_detect: DTMF key detector. Measures a row and a column tone, pairs
// them on every column measurement and qualifies a stable pair as a key.
// Ports:
//   clk, rst_n          system clock, async active-low reset
//   tone_row, tone_col  raw tone inputs, asynchronous to clk
//   key_code            code of the last qualified key (held after release)
//   key_valid           1-cycle pulse when a new key is qualified
//   key_down            high while the key is held
//
// state      | meaning
// -----------+--------------------------------------------------------
// ST_IDLE    | no key; waiting for a valid row/col pair
// ST_QUALIFY | candidate pair seen, counting consecutive matches
// ST_PRESSED | key reported; counting consecutive misses to release
module dtmf_detect
    import dtmf_pkg::*;
#(
    parameter int CLK_DIV       = 12,
    parameter int STABLE_COUNT  = 4,
    parameter int RELEASE_COUNT = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tone_row,
    input  logic       tone_col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down
);

    localparam int              PRE_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);
    localparam logic [7:0]      HITS_LAST = 8'(STABLE_COUNT - 1);
    localparam logic [7:0]      MISS_LAST = 8'(RELEASE_COUNT - 1);

    logic [PRE_W-1:0] pre;
    logic             tick;
    logic             row_meas, row_vld, col_meas, col_vld;
    logic [1:0]       row_cls, col_cls;
    logic             pair_ok;
    logic [3:0]       pair;

    dtmf_state_e state, state_n;
    logic [3:0]  cand, cand_n;
    logic [7:0]  hits, hits_n;
    logic [7:0]  miss, miss_n;
    logic [3:0]  key_code_n;
    logic        key_valid_n, key_down_n;

    assign tick = (pre == PRE_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pre <= '0;
        else
            pre <= tick ? '0 : pre + PRE_W'(1);
    end

    dtmf_tone_period #(.BAND(BAND_ROW)) u_row (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick),
        .tone  (tone_row),
        .meas  (row_meas),
        .vld   (row_vld),
        .cls   (row_cls)
    );

    dtmf_tone_period #(.BAND(BAND_COL)) u_col (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick),
        .tone  (tone_col),
        .meas  (col_meas),
        .vld   (col_vld),
        .cls   (col_cls)
    );

    // row_vld/row_cls already carry a same-cycle row result.
    assign pair_ok = col_meas && col_vld && row_vld;
    assign pair    = {row_cls, col_cls};

    always_comb begin
        state_n     = state;
        cand_n      = cand;
        hits_n      = hits;
        miss_n      = miss;
        key_code_n  = key_code;
        key_valid_n = 1'b0;
        key_down_n  = key_down;
        case (state)
            ST_IDLE: begin
                if (pair_ok) begin
                    cand_n  = pair;
                    hits_n  = 8'd1;
                    state_n = ST_QUALIFY;
                end
            end
            ST_QUALIFY: begin
                if (col_meas) begin
                    if (!pair_ok) begin
                        state_n = ST_IDLE;
                    end else if (pair != cand) begin
                        cand_n = pair;
                        hits_n = 8'd1;
                    end else if (hits >= HITS_LAST) begin
                        hits_n      = hits + 8'd1;
                        key_code_n  = key_map(cand[3:2], cand[1:0]);
                        key_valid_n = 1'b1;
                        key_down_n  = 1'b1;
                        miss_n      = 8'd0;
                        state_n     = ST_PRESSED;
                    end else begin
                        hits_n = hits + 8'd1;
                    end
                end
            end
            ST_PRESSED: begin
                if (col_meas) begin
                    if (pair_ok && pair == cand) begin
                        miss_n = 8'd0;
                    end else if (miss >= MISS_LAST) begin
                        miss_n     = 8'd0;
                        key_down_n = 1'b0;
                        state_n    = ST_IDLE;
                    end else begin
                        miss_n = miss + 8'd1;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cand      <= 4'd0;
            hits      <= 8'd0;
            miss      <= 8'd0;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            key_down  <= 1'b0;
        end else begin
            state     <= state_n;
            cand      <= cand_n;
            hits      <= hits_n;
            miss      <= miss_n;
            key_code  <= key_code_n;
            key_valid <= key_valid_n;
            key_down  <= key_down_n;
        end
    end

endmodule

// File: tb/tb_dtmf_detect.sv
// tb_dtmf_detect: directed bench for dtmf_detect. Runs with a 1-clock tick
// so tone periods are given directly in clock cycles, STABLE_COUNT=2 and
// RELEASE_COUNT=3 to keep the run short.
module tb_dtmf_detect;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tone_row = 1'b0;
    logic       tone_col = 1'b0;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_down;

    int row_per = 0, col_per = 0, row_ph = 0, col_ph = 0;
    int n_checks = 0, n_fail = 0;
    int vcount = 0;
    logic [3:0] vcode = 4'h0;
    bit down_fell = 1'b0;
    logic down_prev = 1'b0;
    int cyc = 0;

    logic [3:0] kmap [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
    int row_p [4] = '{1435, 1300, 1175, 1063};
    int col_p [4] = '{827, 749, 677, 612};

    dtmf_detect #(.CLK_DIV(1), .STABLE_COUNT(2), .RELEASE_COUNT(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tone_row  (tone_row),
        .tone_col  (tone_col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_down  (key_down)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Square-wave tone sources; a period of 0 stops the tone immediately.
    always @(negedge clk) begin
        if (row_per == 0) begin
            tone_row = 1'b0;
            row_ph   = 0;
        end else begin
            tone_row = (row_ph < row_per / 2);
            row_ph   = (row_ph + 1 >= row_per) ? 0 : row_ph + 1;
        end
        if (col_per == 0) begin
            tone_col = 1'b0;
            col_ph   = 0;
        end else begin
            tone_col = (col_ph < col_per / 2);
            col_ph   = (col_ph + 1 >= col_per) ? 0 : col_ph + 1;
        end
    end

    always @(negedge clk) begin
        if (key_valid) begin
            vcount = vcount + 1;
            vcode  = key_code;
        end
        if (down_prev && !key_down) down_fell = 1'b1;
        down_prev = key_down;
    end

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        row_per = 0;
        col_per = 0;
        rst_n   = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic start(input int r, input int c);
        row_per = r;
        col_per = c;
    endtask

    task automatic wait_valid(input int max_cycles, output bit got);
        int start_cnt;
        start_cnt = vcount;
        got = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (vcount != start_cnt) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (key_code !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_key_code: got %h expected %h", key_code, 4'h0);
        end
        n_checks++;
        if (key_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_key_valid: got %b expected 0", key_valid);
        end
        n_checks++;
        if (key_down !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_key_down: got %b expected 0", key_down);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        bit got;
        int v0;
        do_reset();
        v0 = vcount;
        start(1435, 827);
        wait_valid(3500, got);
        n_checks++;
        if (!got || vcode !== 4'h1) begin
            n_fail++;
            $display("FAIL basic_key: got %h (seen %0d) expected 1", vcode, got);
        end
        run(10);
        n_checks++;
        if (key_down !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_down: got %b expected 1", key_down);
        end
        run(1000);
        n_checks++;
        if (vcount - v0 != 1) begin
            n_fail++;
            $display("FAIL basic_single_pulse: got %0d pulses expected 1", vcount - v0);
        end
        start(0, 0);
        run(5000);
        n_checks++;
        if (key_down !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_hold_two_timeouts: got %b expected 1", key_down);
        end
        run(1500);
        n_checks++;
        if (key_down !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_release: got %b expected 0", key_down);
        end
        n_checks++;
        if (key_code !== 4'h1) begin
            n_fail++;
            $display("FAIL basic_code_held: got %h expected 1", key_code);
        end
    endtask

    task automatic test_sweep();
        bit got;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                do_reset();
                start(row_p[r], col_p[c]);
                wait_valid(3500, got);
                n_checks++;
                if (!got || vcode !== kmap[r*4+c]) begin
                    n_fail++;
                    $display("FAIL sweep_r%0d_c%0d: got %h (seen %0d) expected %h",
                             r, c, vcode, got, kmap[r*4+c]);
                end
            end
        end
    endtask

    task automatic test_invalid_col();
        int v0;
        do_reset();
        v0 = vcount;
        start(1435, 909);
        run(3200);
        n_checks++;
        if (vcount != v0) begin
            n_fail++;
            $display("FAIL invalid_col_valid: got %0d pulses expected 0", vcount - v0);
        end
        n_checks++;
        if (key_down !== 1'b0) begin
            n_fail++;
            $display("FAIL invalid_col_down: got %b expected 0", key_down);
        end
    endtask

    task automatic test_glitch();
        bit got;
        int v1;
        do_reset();
        start(1435, 827);
        wait_valid(3500, got);
        n_checks++;
        if (!got || vcode !== 4'h1) begin
            n_fail++;
            $display("FAIL glitch_first_key: got %h (seen %0d) expected 1", vcode, got);
        end
        v1 = vcount;
        @(posedge tone_col);
        col_per = 677;
        @(posedge tone_col);
        @(posedge tone_col);
        col_per = 827;
        run(1500);
        n_checks++;
        if (key_down !== 1'b1) begin
            n_fail++;
            $display("FAIL glitch_hold: got %b expected 1", key_down);
        end
        n_checks++;
        if (vcount != v1) begin
            n_fail++;
            $display("FAIL glitch_no_repeat: got %0d pulses expected 0", vcount - v1);
        end
        down_fell = 1'b0;
        @(posedge tone_row);
        start(1300, 677);
        wait_valid(6000, got);
        n_checks++;
        if (!got || vcode !== 4'h6) begin
            n_fail++;
            $display("FAIL glitch_new_key: got %h (seen %0d) expected 6", vcode, got);
        end
        n_checks++;
        if (down_fell !== 1'b1) begin
            n_fail++;
            $display("FAIL glitch_release_first: got %b expected 1", down_fell);
        end
    endtask

    task automatic test_reset_mid();
        bit got;
        int v0, t0;
        do_reset();
        v0 = vcount;
        start(1300, 749);
        t0 = cyc;
        while (cyc < t0 + 1800) @(negedge clk);
        n_checks++;
        if (vcount != v0) begin
            n_fail++;
            $display("FAIL qualify_early: got %0d pulses expected 0", vcount - v0);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (key_down !== 1'b0 || key_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL qualify_reset_outputs: got down %b valid %b expected 0 0", key_down, key_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        while (cyc < t0 + 5000) @(negedge clk);
        n_checks++;
        if (vcount != v0) begin
            n_fail++;
            $display("FAIL requalify_early: got %0d pulses expected 0", vcount - v0);
        end
        wait_valid(900, got);
        n_checks++;
        if (!got || vcode !== 4'h5) begin
            n_fail++;
            $display("FAIL requalify_key: got %h (seen %0d) expected 5", vcode, got);
        end
        run(50);
        n_checks++;
        if (key_down !== 1'b1) begin
            n_fail++;
            $display("FAIL pressed_before_reset: got %b expected 1", key_down);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (key_down !== 1'b0) begin
            n_fail++;
            $display("FAIL pressed_reset_down: got %b expected 0", key_down);
        end
        n_checks++;
        if (key_code !== 4'h0) begin
            n_fail++;
            $display("FAIL pressed_reset_code: got %h expected 0", key_code);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_boundary();
        int b_row [6] = '{1400, 1470, 1399, 1471, 1435, 1435};
        int b_col [6] = '{827, 827, 827, 827, 597, 596};
        bit b_exp [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [3:0] b_code [6] = '{4'h1, 4'h1, 4'h0, 4'h0, 4'hA, 4'h0};
        bit got;
        int v0;
        for (int i = 0; i < 6; i++) begin
            do_reset();
            v0 = vcount;
            start(b_row[i], b_col[i]);
            if (b_exp[i]) begin
                wait_valid(3500, got);
                n_checks++;
                if (!got || vcode !== b_code[i]) begin
                    n_fail++;
                    $display("FAIL boundary_r%0d_c%0d: got %h (seen %0d) expected %h",
                             b_row[i], b_col[i], vcode, got, b_code[i]);
                end
            end else begin
                run(2700);
                n_checks++;
                if (vcount != v0) begin
                    n_fail++;
                    $display("FAIL boundary_r%0d_c%0d: got %0d pulses expected 0",
                             b_row[i], b_col[i], vcount - v0);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sweep();
        test_invalid_col();
        test_glitch();
        test_reset_mid();
        test_boundary();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
